fifo_drain_tx: RTL and testbench

- UDB-side consumer for the byte FIFO that the CPU/DMA fills through bus writes.
- Holds a small byte FIFO and pops bytes in order.
- Shifts each byte out MSB-first on a framed serial link with a divided bit clock.
- Raises a DMA request whenever there is room, so the bus side can keep the FIFO topped up without polling.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/byte_fifo.sv | 88 ++++++++
 rtl/fifo_drain_tx.sv | 149 ++++++++++++++
 tb/tb_fifo_drain_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared types, default sizes and a width helper for fifo_drain_tx
// Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

   // Serializer states: waiting for data, or shifting a word out
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEPTH_DEF = 4;
   localparam int WIDTH_DEF = 8;
   localparam int DIV_DEF   = 2;

   // Bits needed to index n entries; never below 1 so vectors stay legal
   function automatic int ptr_width(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Brief    : Circular word FIFO with registered full/empty and sticky overflow
// Revision : 1.0  initial release
// ============================================================================
module byte_fifo
   import fifo_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_not_full,
   output logic             o_empty,
   output logic             o_overflow
);

   localparam int              c_PW      = ptr_width(DEPTH);
   localparam logic [c_PW:0]   c_FULL    = (c_PW+1)'(DEPTH);
   localparam logic [c_PW:0]   c_CNT_ONE = (c_PW+1)'(1);
   localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]  r_wr_ptr;
   logic [c_PW-1:0]  r_rd_ptr;
   logic [c_PW:0]    r_count;
   logic [c_PW:0]    w_count_nxt;
   logic             r_not_full;
   logic             r_empty;
   logic             r_overflow;
   logic             w_wr_ok;
   logic             w_rd_ok;

   // Acceptance is judged on the count before the edge, so a write while full
   // is dropped even if a pop frees a slot on the same edge
   assign w_wr_ok = i_wr_en && (r_count != c_FULL);
   assign w_rd_ok = i_rd_en && (r_count != '0);

   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_not_full = r_not_full;
   assign o_empty    = r_empty;
   assign o_overflow = r_overflow;

   // Occupancy after this edge; a simultaneous write and pop cancel out
   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_ok && !w_rd_ok)
         w_count_nxt = r_count + c_CNT_ONE;
      else if (!w_wr_ok && w_rd_ok)
         w_count_nxt = r_count - c_CNT_ONE;
   end

   // Storage array; stale contents are harmless once the pointers are reset
   always_ff @(posedge clock) begin
      if (w_wr_ok)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers, occupancy and status flags registered from the post-edge count
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_not_full <= 1'b1;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_ok)
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_rd_ok)
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         r_count    <= w_count_nxt;
         r_not_full <= (w_count_nxt != c_FULL);
         r_empty    <= (w_count_nxt == '0);
         if (i_wr_en && !w_wr_ok)
            r_overflow <= 1'b1;
      end
   end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/fifo_drain_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_tx
// Brief    : Drains a byte FIFO onto a framed MSB-first serial link with a
//            divided bit clock; requests DMA refill whenever there is room
// Revision : 1.0  initial release
// ============================================================================
module fifo_drain_tx
   import fifo_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIV   = DIV_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             f0_not_full,
   output logic             f0_empty,
   output logic             drq,
   output logic             overflow,
   output logic             ser_out,
   output logic             ser_clk,
   output logic             ser_frame,
   output logic             busy
);

   localparam int             c_DW       = ptr_width(DIV);
   localparam int             c_BW       = ptr_width(WIDTH);
   localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(DIV - 1);
   localparam logic [c_DW-1:0] c_DIV_HALF = c_DW'(DIV / 2);
   localparam logic [c_DW-1:0] c_DIV_ONE  = c_DW'(1);
   localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
   localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [c_BW-1:0]  r_bit_cnt;
   logic [c_DW-1:0]  r_div_cnt;
   logic [WIDTH-1:0] w_fifo_rd_data;
   logic             w_fifo_not_full;
   logic             w_fifo_empty;
   logic             w_fifo_overflow;
   logic             w_div_last;
   logic             w_word_last;
   logic             w_pop;
   logic             w_frame_d;
   logic             w_clk_d;
   logic             w_out_d;

   byte_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_wr_en    (wr_en),
      .i_wr_data  (wr_data),
      .i_rd_en    (w_pop),
      .o_rd_data  (w_fifo_rd_data),
      .o_not_full (w_fifo_not_full),
      .o_empty    (w_fifo_empty),
      .o_overflow (w_fifo_overflow)
   );

   assign f0_not_full = w_fifo_not_full;
   assign f0_empty    = w_fifo_empty;
   assign drq         = w_fifo_not_full;
   assign overflow    = w_fifo_overflow;

   // The registered empty flag reflects the current count, so it gates pops
   assign w_div_last  = (r_div_cnt == c_DIV_LAST);
   assign w_word_last = w_div_last && (r_bit_cnt == c_BIT_LAST);
   assign w_pop       = !w_fifo_empty &&
                        ((r_state == IDLE) || ((r_state == SHIFT) && w_word_last));

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state: start on data, leave only when a word ends with nothing queued
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (!w_fifo_empty) w_state_nxt = SHIFT;
         SHIFT:   if (w_word_last && w_fifo_empty) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Serial output values implied by the current state and counters
   always_comb begin
      w_frame_d = 1'b0;
      w_clk_d   = 1'b0;
      w_out_d   = 1'b0;
      case (r_state)
         SHIFT: begin
            w_frame_d = 1'b1;
            w_clk_d   = (r_div_cnt >= c_DIV_HALF);
            w_out_d   = r_shift[WIDTH-1];
         end
         default: ;
      endcase
   end

   // Shift register and bit/divider counters; a pop reloads and restarts them
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_div_cnt <= '0;
      end else if (w_pop) begin
         r_shift   <= w_fifo_rd_data;
         r_bit_cnt <= '0;
         r_div_cnt <= '0;
      end else if (r_state == SHIFT) begin
         if (w_div_last) begin
            r_div_cnt <= '0;
            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
         end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
         end
      end
   end

   // Register every serial output so nothing reaches a pin combinationally
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ser_frame <= 1'b0;
         ser_clk   <= 1'b0;
         ser_out   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ser_frame <= w_frame_d;
         ser_clk   <= w_clk_d;
         ser_out   <= w_out_d;
         busy      <= (w_state_nxt != IDLE);
      end
   end

endmodule : fifo_drain_tx
`default_nettype wire

// File: tb/tb_fifo_drain_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_drain_tx
// Brief    : Randomized and directed bench for fifo_drain_tx with a queue-based
//            reference model and a serial-byte scoreboard
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_drain_tx;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;
   localparam int DIV   = 2;
   localparam int WD    = WIDTH * DIV;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_en   = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       f0_not_full, f0_empty, drq, overflow;
   logic       ser_out, ser_clk, ser_frame, busy;
   logic [7:0] dut_vec;

   int checks = 0;
   int errors = 0;

   fifo_drain_tx #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DIV(DIV)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .f0_not_full (f0_not_full),
      .f0_empty    (f0_empty),
      .drq         (drq),
      .overflow    (overflow),
      .ser_out     (ser_out),
      .ser_clk     (ser_clk),
      .ser_frame   (ser_frame),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   assign dut_vec = {f0_not_full, f0_empty, drq, overflow, ser_out, ser_clk, ser_frame, busy};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: queue + cycles left in current word
   logic [7:0] m_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] m_word;
   logic [7:0] m_exp;
   int         m_rem   = 0;
   int         m_pos;
   int         m_size;
   bit         m_valid = 0;
   bit         m_ovf, m_fr, m_ck, m_so, m_acc, m_pop;

   always @(posedge clock) begin
      if (!reset_n) begin
         m_q.delete();
         exp_q.delete();
         m_rem   = 0;
         m_ovf   = 0;
         m_word  = 8'h00;
         m_exp   = 8'b1110_0000;
         m_valid = 1;
      end else if (m_valid) begin
         m_size = m_q.size();
         m_fr = (m_rem > 0);
         m_ck = 0;
         m_so = 0;
         if (m_fr) begin
            m_pos = WD - m_rem;
            m_ck  = ((m_pos % DIV) >= (DIV / 2));
            m_so  = m_word[WIDTH - 1 - m_pos / DIV];
         end
         m_acc = wr_en && (m_size < DEPTH);
         if (wr_en && !m_acc) m_ovf = 1;
         m_pop = (m_size > 0) && (m_rem <= 1);
         if (m_rem > 0) m_rem--;
         if (m_pop) begin
            m_word = m_q.pop_front();
            exp_q.push_back(m_word);
            m_rem = WD;
         end
         if (m_acc) m_q.push_back(wr_data);
         m_exp = {(m_q.size() < DEPTH), (m_q.size() == 0), (m_q.size() < DEPTH),
                  m_ovf, m_so, m_ck, m_fr, (m_rem > 0)};
      end
   end

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clock) begin
      if (m_valid) chk("outputs", 32'(dut_vec), 32'(m_exp));
   end

   // ---------------- scoreboard: rebuild bytes from ser_clk rising edges
   logic [7:0] rx_sh = 8'h00;
   logic [7:0] exp_b;
   int         rx_bits  = 0;
   int         rx_bytes = 0;
   logic       prev_clk = 1'b0;

   always @(negedge clock) begin
      if (!reset_n) begin
         rx_bits  = 0;
         prev_clk = 1'b0;
      end else begin
         if (ser_frame && ser_clk && !prev_clk) begin
            rx_sh = {rx_sh[6:0], ser_out};
            rx_bits++;
            if (rx_bits == WIDTH) begin
               rx_bits = 0;
               rx_bytes++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: got %0h expected none at %0t", rx_sh, $time);
               end else begin
                  exp_b = exp_q.pop_front();
                  chk("sb_byte", 32'(rx_sh), 32'(exp_b));
               end
            end
         end
         prev_clk = ser_clk;
      end
   end

   // ---------------- stimulus helpers
   task automatic do_reset();
      reset_n = 1'b0;
      wr_en   = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      wr_en = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   logic [7:0] t2_vals [4];
   int  first_i, last_i, fcnt, nw;
   bit  found;

   initial begin
      t2_vals[0] = 8'hFF; t2_vals[1] = 8'h88; t2_vals[2] = 8'h44; t2_vals[3] = 8'h11;

      // T1: reset then quiet idle
      do_reset();
      idle(20);
      chk("t1_idle", 32'({f0_not_full, f0_empty, drq, overflow, ser_frame}), 32'(5'b11100));

      // T2: four consecutive writes, frame timing
      first_i = -1; fcnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (i < 4) begin
            wr_en = 1'b1;
            wr_data = t2_vals[i];
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clock);
         if (ser_frame) begin
            fcnt++;
            if (first_i < 0) first_i = i;
         end
      end
      chk("t2_frame_start", 32'(first_i), 32'(2));
      chk("t2_frame_len", 32'(fcnt), 32'(64));
      chk("t2_empty", 32'(f0_empty), 32'(1));

      // T3: fill while busy, sixth write overflows
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1;
         wr_data = 8'hA0 + 8'(i);
         @(negedge clock);
         if (i == 4) begin
            chk("t3_not_full", 32'(f0_not_full), 32'(0));
            chk("t3_drq", 32'(drq), 32'(0));
            chk("t3_ovf_pre", 32'(overflow), 32'(0));
         end
      end
      chk("t3_ovf", 32'(overflow), 32'(1));
      idle(120);

      // T4: write on the pop edge while full is rejected, next one accepted
      do_reset();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1;
         wr_data = 8'hB0 + 8'(i);
         @(negedge clock);
      end
      wr_en = 1'b0;
      found = 0;
      for (int i = 0; i < 120 && !found; i++) begin
         if (m_rem == 1 && m_q.size() == DEPTH) found = 1;
         else @(negedge clock);
      end
      chk("t4_hit", 32'(found), 32'(1));
      chk("t4_ovf_pre", 32'(overflow), 32'(0));
      wr_en = 1'b1; wr_data = 8'hC0;
      @(negedge clock);
      chk("t4_ovf", 32'(overflow), 32'(1));
      wr_en = 1'b1; wr_data = 8'hC1;
      @(negedge clock);
      wr_en = 1'b0;
      chk("t4_refill", 32'(f0_not_full), 32'(0));
      idle(150);

      // T5: reset in the middle of A5, then 3C shifts cleanly
      do_reset();
      wr_en = 1'b1; wr_data = 8'hA5;
      @(negedge clock);
      wr_en = 1'b0;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clock);
         if (m_rem == WD - 3 * DIV) found = 1;
      end
      chk("t5_hit", 32'(found), 32'(1));
      reset_n = 1'b0;
      @(negedge clock);
      chk("t5_reset", 32'(dut_vec), 32'(8'b1110_0000));
      @(negedge clock);
      reset_n = 1'b1;
      wr_en = 1'b1; wr_data = 8'h3C;
      @(negedge clock);
      idle(40);

      // T6: DMA-style fill on drq, 12 words 00..0B back to back
      nw = 0; first_i = -1; last_i = -1; fcnt = 0;
      for (int i = 0; i < 300; i++) begin
         if (nw < 3 * DEPTH && drq) begin
            wr_en = 1'b1;
            wr_data = 8'(nw);
            nw++;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clock);
         if (ser_frame) begin
            fcnt++;
            if (first_i < 0) first_i = i;
            last_i = i;
         end
      end
      chk("t6_words", 32'(nw), 32'(3 * DEPTH));
      chk("t6_frame_len", 32'(fcnt), 32'(3 * DEPTH * WD));
      chk("t6_no_gap", 32'(last_i - first_i + 1), 32'(3 * DEPTH * WD));

      // T7: randomized bursty writes checked by the model and scoreboard
      for (int i = 0; i < 600; i++) begin
         wr_en   = ($urandom_range(0, 99) < 15);
         wr_data = 8'($urandom);
         @(negedge clock);
      end
      idle(120);

      chk("sb_drained", 32'(exp_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fifo_drain_tx
`default_nettype wire
